// File: rtl/microprocesador_equipo_n.sv
// microprocesador_equipo_n
//   Single-cycle 8-bit CPU core of the microUAZ8 system. It executes one 9-bit
//   instruction per clock from an external instruction ROM. It holds an 8-bit PC
//   and eight 8-bit general-purpose registers (R0..R7, all writable), and it
//   accesses an external data RAM through separate address, read and write buses.
//
//   Instruction format: opcode [8:6], field A [5:3], field B [2:0]
//     000 LD  : R[A] <= Datain_Bus, address = R[B]
//     001 ST  : address = R[A], write data = R[B], LE = 1
//     010 ADD : R[A] <= R[A] + R[B]   (carry discarded)
//     011 SUB : R[A] <= R[A] - R[B]   (two's-complement wrap)
//     100 AND / 101 OR / 110 XOR : R[A] <= R[A] op R[B]
//     111 JMP : PC <= {2'b00, A, B}
//   Every instruction other than JMP advances the PC by one, wrapping at 0xFF.
//
// Ports
//   Clk                      in   system clock, rising edge
//   Rst                      in   asynchronous reset, active low
//   Instruction[8:0]         in   current instruction word
//   Datain_Bus[7:0]          in   data-memory read data
//   Address_Instruction_Bus  out  instruction address (the PC)
//   Addres_Data_Bus[7:0]     out  data-memory address (LD/ST only, otherwise 0)
//   DataOut_Bus[7:0]         out  data-memory write data (ST only, otherwise 0)
//   LE                       out  data-memory write enable (ST only)

module microprocesador_equipo_n (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [8:0] Instruction,
  input  logic [7:0] Datain_Bus,
  output logic [7:0] Address_Instruction_Bus,
  output logic [7:0] Addres_Data_Bus,
  output logic [7:0] DataOut_Bus,
  output logic       LE
);

  typedef enum logic [2:0] {
    OP_LD  = 3'b000,
    OP_ST  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_JMP = 3'b111
  } opcode_t;

  opcode_t    opcode;
  logic [2:0] field_a;
  logic [2:0] field_b;

  logic [7:0] pc;
  logic [7:0] regs [0:7];

  logic [7:0] ra;
  logic [7:0] rb;
  logic       reg_we;
  logic [7:0] reg_wdata;
  logic [7:0] pc_next;

  logic [7:0] data_addr;
  logic [7:0] data_out;
  logic       write_en;

  assign opcode  = opcode_t'(Instruction[8:6]);
  assign field_a = Instruction[5:3];
  assign field_b = Instruction[2:0];

  // Operands are read before the edge, so A = B cases naturally see old values.
  assign ra = regs[field_a];
  assign rb = regs[field_b];

  always_comb begin
    reg_we    = 1'b1;
    reg_wdata = '0;
    pc_next   = pc + 8'd1;
    data_addr = '0;
    data_out  = '0;
    write_en  = 1'b0;

    unique case (opcode)
      OP_LD: begin
        data_addr = rb;
        reg_wdata = Datain_Bus;
      end
      OP_ST: begin
        reg_we    = 1'b0;
        data_addr = ra;
        data_out  = rb;
        write_en  = 1'b1;
      end
      OP_ADD: reg_wdata = ra + rb;
      OP_SUB: reg_wdata = ra - rb;
      OP_AND: reg_wdata = ra & rb;
      OP_OR:  reg_wdata = ra | rb;
      OP_XOR: reg_wdata = ra ^ rb;
      OP_JMP: begin
        reg_we  = 1'b0;
        pc_next = {2'b00, field_a, field_b};
      end
      default: reg_we = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else begin
      pc <= pc_next;
      if (reg_we) begin
        regs[field_a] <= reg_wdata;
      end
    end
  end

  // Memory-side outputs are combinational from the instruction, so they are
  // forced quiet while reset is held (a ST present during reset must not write).
  assign Address_Instruction_Bus = pc;
  assign Addres_Data_Bus         = Rst ? data_addr : '0;
  assign DataOut_Bus             = Rst ? data_out  : '0;
  assign LE                      = Rst & write_en;

endmodule

// File: tb/tb_microprocesador_equipo_n.sv
// Directed bench for microprocesador_equipo_n. Registers are observed through
// the combinational ST path (ST R0,Rx drives DataOut_Bus = Rx) without clocking.

module tb_microprocesador_equipo_n;

  logic       Clk;
  logic       Rst;
  logic [8:0] Instruction;
  logic [7:0] Datain_Bus;
  logic [7:0] Address_Instruction_Bus;
  logic [7:0] Addres_Data_Bus;
  logic [7:0] DataOut_Bus;
  logic       LE;

  int unsigned checks;
  int unsigned failures;
  logic [7:0]  exp_pc;

  microprocesador_equipo_n dut (
    .Clk                     (Clk),
    .Rst                     (Rst),
    .Instruction             (Instruction),
    .Datain_Bus              (Datain_Bus),
    .Address_Instruction_Bus (Address_Instruction_Bus),
    .Addres_Data_Bus         (Addres_Data_Bus),
    .DataOut_Bus             (DataOut_Bus),
    .LE                      (LE)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // Execute one instruction across a rising edge; sample 1 time unit later.
  task automatic exec(input logic [8:0] instr);
    Instruction = instr;
    @(posedge Clk);
    #1;
    if (instr[8:6] == 3'b111) exp_pc = {2'b00, instr[5:0]};
    else                      exp_pc = exp_pc + 8'd1;
    check_eq("pc", Address_Instruction_Bus, exp_pc);
  endtask

  // Combinational register read via ST R0,Rx; no clock edge is consumed.
  task automatic read_reg(input string tag, input logic [2:0] idx, input logic [7:0] exp);
    Instruction = {3'b001, 3'b000, idx};
    #1;
    check_eq(tag, DataOut_Bus, exp);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_pc      = 8'h00;
    Rst         = 1'b0;
    Datain_Bus  = 8'h00;
    Instruction = 9'b001_000_000;

    // Reset held for three edges with a ST on the bus.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check_eq("rst_pc",   Address_Instruction_Bus, 8'h00);
      check_eq("rst_le",   {7'b0, LE},              8'h00);
      check_eq("rst_addr", Addres_Data_Bus,         8'h00);
      check_eq("rst_dout", DataOut_Bus,             8'h00);
    end

    Rst = 1'b1;
    #1;
    check_eq("st_le_after_release", {7'b0, LE}, 8'h01);
    exec(9'b001_000_000);                       // PC 0 -> 1
    exec(9'b001_000_000);                       // PC 1 -> 2

    // LD R2,[R2] with R2 = 0
    Datain_Bus  = 8'h16;
    Instruction = 9'b000_010_010;
    #1;
    check_eq("ld_addr", Addres_Data_Bus, 8'h00);
    check_eq("ld_le",   {7'b0, LE},      8'h00);
    exec(9'b000_010_010);
    read_reg("ld_r2", 3'd2, 8'h16);

    // ADD R2,R2 doubles
    exec(9'b010_010_010);
    read_reg("add_r2", 3'd2, 8'h2C);

    // ST [R0],R2
    Instruction = 9'b001_000_010;
    #1;
    check_eq("st_addr", Addres_Data_Bus, 8'h00);
    check_eq("st_dout", DataOut_Bus,     8'h2C);
    check_eq("st_le",   {7'b0, LE},      8'h01);
    exec(9'b001_000_010);
    read_reg("st_r2_kept", 3'd2, 8'h2C);
    read_reg("st_r0_kept", 3'd0, 8'h00);

    // Non-memory opcode: buses idle, LE low
    Instruction = 9'b100_001_001;
    #1;
    check_eq("alu_le",   {7'b0, LE},      8'h00);
    check_eq("alu_addr", Addres_Data_Bus, 8'h00);
    check_eq("alu_dout", DataOut_Bus,     8'h00);
    exec(9'b100_001_001);

    // LD R2,[R2] uses the old R2 (0x2C) as address
    Datain_Bus  = 8'h16;
    Instruction = 9'b000_010_010;
    #1;
    check_eq("ld_same_addr", Addres_Data_Bus, 8'h2C);
    exec(9'b000_010_010);
    read_reg("ld_r2_again", 3'd2, 8'h16);

    // SUB wrap: R0 = 0 - 0x16
    exec(9'b011_000_010);
    read_reg("sub_wrap", 3'd0, 8'hEA);
    exec(9'b100_000_010);
    read_reg("and_r0", 3'd0, 8'h02);

    exec(9'b011_000_000);                       // SUB R0,R0 clears
    read_reg("sub_self", 3'd0, 8'h00);
    exec(9'b011_000_010);
    exec(9'b101_000_010);
    read_reg("or_r0", 3'd0, 8'hFE);

    exec(9'b011_000_000);
    exec(9'b011_000_010);
    exec(9'b110_000_010);
    read_reg("xor_r0", 3'd0, 8'hFC);

    // ST [R2],R0: address from rA
    Instruction = 9'b001_010_000;
    #1;
    check_eq("st_ra_addr", Addres_Data_Bus, 8'h16);
    check_eq("st_rb_dout", DataOut_Bus,     8'hFC);

    // LD R5,[R2], then ADD with discarded carry
    Datain_Bus  = 8'h5A;
    Instruction = 9'b000_101_010;
    #1;
    check_eq("ld_rb_addr", Addres_Data_Bus, 8'h16);
    exec(9'b000_101_010);
    read_reg("ld_r5", 3'd5, 8'h5A);
    exec(9'b010_101_000);                       // 0x5A + 0xFC = 0x156
    read_reg("add_carry", 3'd5, 8'h56);

    // JMP
    exec(9'b111_100_100);
    check_eq("jmp_24", Address_Instruction_Bus, 8'h24);
    exec(9'b111_111_111);
    check_eq("jmp_3f", Address_Instruction_Bus, 8'h3F);

    // Walk to 0xFF with non-JMP instructions, then wrap
    while (exp_pc != 8'hFF) exec(9'b100_001_001);
    exec(9'b100_001_001);
    check_eq("pc_wrap", Address_Instruction_Bus, 8'h00);

    // Async reset between edges
    exec(9'b111_100_100);
    read_reg("pre_rst_r5", 3'd5, 8'h56);
    @(negedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    check_eq("async_pc", Address_Instruction_Bus, 8'h00);
    Rst = 1'b1;
    read_reg("async_r2", 3'd2, 8'h00);
    read_reg("async_r5", 3'd5, 8'h00);
    read_reg("async_r0", 3'd0, 8'h00);
    exp_pc = 8'h00;
    exec(9'b100_001_001);                       // first edge runs address 0

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
